// File: rtl/ps2_tx_pkg.sv
// ps2_tx_pkg: PS/2 constants, transmitter FSM encoding and the frame builder.
//   PS2_FRAME_BITS  start + 8 data + parity + stop bits on the wire
//   PS2_CMD_*       common host commands
//   ps2_frame()     {stop, odd parity, data}; the wire order is LSB first
package ps2_tx_pkg;
  localparam int PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK = 8'hFA;
  typedef enum logic [2:0] {IDLE, RTS, START, DATA, ACK, WAITREL} tx_state_t;
  function automatic logic [9:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction
endpackage

// File: rtl/ps2_tx_if.sv
// ps2_tx_if: request/status bundle of the PS/2 transmitter.
//   wr_ps2, din                       request side (driven by master)
//   tx_idle, tx_done_tick, tx_err     status side (driven by slave)
interface ps2_tx_if;
  logic wr_ps2;
  logic [7:0] din;
  logic tx_idle;
  logic tx_done_tick;
  logic tx_err;
  modport master(output wr_ps2, din, input tx_idle, tx_done_tick, tx_err);
  modport slave(input wr_ps2, din, output tx_idle, tx_done_tick, tx_err);
endinterface

// File: rtl/ps2_tx_clk_filter.sv
// ps2_tx_clk_filter: PS2C glitch filter and falling-edge detector.
//   mclk, reset (async, active-low), ps2c_in -> fclk (filtered clock), fall (1-cycle pulse on fclk 1->0)
module ps2_tx_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic mclk,
  input  logic reset,
  input  logic ps2c_in,
  output logic fclk,
  output logic fall
);
  logic [FILTER_LEN-1:0] sh;
  always_ff @(posedge mclk or negedge reset)
    if (!reset) begin
      sh <= '1;
      fclk <= 1'b1;
      fall <= 1'b0;
    end else begin
      sh <= {sh[FILTER_LEN-2:0], ps2c_in};
      fclk <= &sh ? 1'b1 : (~|sh ? 1'b0 : fclk);
      fall <= fclk & ~|sh;
    end
endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter (request-to-send, 11-bit frame, ACK check, watchdog).
//   mclk          system clock
//   reset         asynchronous, active-low
//   bus           ps2_tx_if.slave: wr_ps2/din in, tx_idle/tx_done_tick/tx_err out
//   ps2c, ps2d    open-drain PS/2 lines, driven 0 or released
module ps2_tx
  import ps2_tx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15_000,
  parameter int FILTER_LEN = 8
) (
  input logic     mclk,
  input logic     reset,
  ps2_tx_if.slave bus,
  inout wire      ps2c,
  inout wire      ps2d
);
  localparam logic [19:0] INHIBIT_CYC = 20'(CLK_HZ / 1_000_000 * INHIBIT_US);
  localparam logic [19:0] TIMEOUT_CYC = 20'(CLK_HZ / 1_000_000 * TIMEOUT_US);
  tx_state_t state;
  logic [9:0] sr;
  logic [3:0] n;
  logic [19:0] cnt;
  logic [1:0] d_s;
  logic c_oe, d_oe, fclk, fall, wd_hit;
  assign ps2c = c_oe ? 1'b0 : 1'bz;
  assign ps2d = d_oe ? 1'b0 : 1'bz;
  ps2_tx_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .mclk(mclk), .reset(reset), .ps2c_in(ps2c), .fclk(fclk), .fall(fall)
  );
  // cnt doubles as inhibit timer in RTS and watchdog once PS2C is released
  assign wd_hit = (state inside {DATA, ACK, WAITREL}) && cnt == TIMEOUT_CYC;
  always_ff @(posedge mclk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      sr <= '0;
      n <= '0;
      cnt <= '0;
      d_s <= 2'b11;
      c_oe <= 1'b0;
      d_oe <= 1'b0;
      bus.tx_idle <= 1'b1;
      bus.tx_done_tick <= 1'b0;
      bus.tx_err <= 1'b0;
    end else begin
      d_s <= {d_s[0], ps2d};
      bus.tx_done_tick <= 1'b0;
      cnt <= cnt + 20'd1;
      if (wd_hit) begin
        c_oe <= 1'b0;
        d_oe <= 1'b0;
        bus.tx_err <= 1'b1;
        bus.tx_done_tick <= 1'b1;
        bus.tx_idle <= 1'b1;
        state <= IDLE;
      end else
        case (state)
          IDLE:
            // the done cycle still shows tx_idle=1 but must not accept
            if (bus.wr_ps2 && !bus.tx_done_tick) begin
              sr <= ps2_frame(bus.din);
              n <= '0;
              cnt <= '0;
              c_oe <= 1'b1;
              bus.tx_err <= 1'b0;
              bus.tx_idle <= 1'b0;
              state <= RTS;
            end
          RTS:
            if (cnt == INHIBIT_CYC - 20'd1) begin
              d_oe <= 1'b1;
              state <= START;
            end
          START: begin
            c_oe <= 1'b0;
            cnt <= '0;
            state <= DATA;
          end
          DATA:
            // start bit stays on the line until the first device fall
            if (fall) begin
              d_oe <= ~sr[0];
              sr <= {1'b0, sr[9:1]};
              n <= n + 4'd1;
              if (n == 4'(PS2_FRAME_BITS - 2)) state <= ACK;
            end
          ACK:
            if (fall) begin
              bus.tx_err <= d_s[1];
              state <= WAITREL;
            end
          WAITREL:
            if (fclk && d_s[1]) begin
              bus.tx_done_tick <= 1'b1;
              bus.tx_idle <= 1'b1;
              state <= IDLE;
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed bench for ps2_tx with pull-ups and a keyboard model.
module tb_ps2_tx;
  import ps2_tx_pkg::*;
  localparam int INH = 100;
  localparam int TO_CYC = 5000;
  localparam int H = 20;
  logic mclk = 1'b0;
  logic reset = 1'b0;
  logic kc = 1'b0;
  logic kd = 1'b0;
  wire ps2c, ps2d;
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int d0, t, low_cyc;
  logic err_at_done, idle_at_done, sb;
  logic [9:0] got;
  ps2_tx_if bus();
  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = kc ? 1'b0 : 1'bz;
  assign ps2d = kd ? 1'b0 : 1'bz;
  ps2_tx #(.CLK_HZ(50_000_000), .INHIBIT_US(2), .TIMEOUT_US(100), .FILTER_LEN(2)) dut (
    .mclk(mclk), .reset(reset), .bus(bus), .ps2c(ps2c), .ps2d(ps2d)
  );
  always #5 mclk = ~mclk;
  always @(negedge mclk)
    if (bus.tx_done_tick) begin
      done_cnt++;
      err_at_done = bus.tx_err;
      idle_at_done = bus.tx_idle;
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic request(input logic [7:0] d);
    bus.din = d;
    bus.wr_ps2 = 1'b1;
    @(negedge mclk);
    bus.wr_ps2 = 1'b0;
  endtask
  task automatic wait_done(input int base, input int budget, output int cyc);
    cyc = 0;
    while (done_cnt == base && cyc < budget) begin
      @(negedge mclk);
      cyc++;
    end
  endtask
  task automatic kbd(input logic ack, input logic pulse, input logic glitch,
                     output logic [9:0] bits, output int low, output logic start_bit);
    int w = 0;
    bits = '0;
    low = 0;
    while (ps2c !== 1'b0 && w < 1000) begin
      @(negedge mclk);
      w++;
    end
    while (ps2c === 1'b0 && low < 1000) begin
      @(negedge mclk);
      low++;
    end
    start_bit = ps2d;
    for (int k = 1; k <= 11; k++) begin
      repeat (H / 2) @(negedge mclk);
      if (glitch && k == 4) begin
        kc = 1'b1;
        @(negedge mclk);
        kc = 1'b0;
      end
      if (pulse) begin
        bus.din = 8'h55;
        bus.wr_ps2 = 1'b1;
        @(negedge mclk);
        bus.wr_ps2 = 1'b0;
      end
      if (k == 11) kd = ack;
      repeat (H / 2) @(negedge mclk);
      kc = 1'b1;
      repeat (H) @(negedge mclk);
      if (k <= 10) bits[k-1] = ps2d;
      kc = 1'b0;
    end
    repeat (H) @(negedge mclk);
    kd = 1'b0;
  endtask
  initial begin
    bus.wr_ps2 = 1'b0;
    bus.din = 8'h00;
    repeat (3) @(negedge mclk);
    chk("rst_ps2c", 32'(ps2c), 1);
    chk("rst_ps2d", 32'(ps2d), 1);
    chk("rst_idle", 32'(bus.tx_idle), 1);
    chk("rst_err", 32'(bus.tx_err), 0);
    chk("rst_done", 32'(bus.tx_done_tick), 0);
    reset = 1'b1;
    repeat (3) @(negedge mclk);
    d0 = done_cnt;
    request(PS2_CMD_SET_LED);
    chk("ed_busy", 32'(bus.tx_idle), 0);
    kbd(1'b1, 1'b0, 1'b0, got, low_cyc, sb);
    chk("ed_inhibit", 32'(low_cyc >= INH && low_cyc <= INH + 3), 1);
    chk("ed_start", 32'(sb), 0);
    chk("ed_bits", 32'(got), 32'h3ED);
    wait_done(d0, 200, t);
    repeat (5) @(negedge mclk);
    chk("ed_done", 32'(done_cnt), 32'(d0 + 1));
    chk("ed_err", 32'(err_at_done), 0);
    chk("ed_idle", 32'(idle_at_done), 1);
    d0 = done_cnt;
    request(8'h00);
    kbd(1'b0, 1'b0, 1'b0, got, low_cyc, sb);
    chk("nack_bits", 32'(got), 32'h300);
    wait_done(d0, 200, t);
    repeat (5) @(negedge mclk);
    chk("nack_done", 32'(done_cnt), 32'(d0 + 1));
    chk("nack_err", 32'(err_at_done), 1);
    chk("nack_err_hold", 32'(bus.tx_err), 1);
    d0 = done_cnt;
    request(PS2_CMD_SET_LED);
    repeat (20) @(negedge mclk);
    chk("rts_low", 32'(ps2c), 0);
    reset = 1'b0;
    #1;
    chk("rts_rst_ps2c", 32'(ps2c), 1);
    chk("rts_rst_ps2d", 32'(ps2d), 1);
    chk("rts_rst_idle", 32'(bus.tx_idle), 1);
    chk("rts_rst_err", 32'(bus.tx_err), 0);
    repeat (3) @(negedge mclk);
    reset = 1'b1;
    repeat (200) @(negedge mclk);
    chk("rts_rst_nodone", 32'(done_cnt), 32'(d0));
    chk("rts_rst_line", 32'(ps2c), 1);
    d0 = done_cnt;
    request(PS2_CMD_SET_LED);
    t = 0;
    while (ps2c !== 1'b1 && t < 1000) begin
      @(negedge mclk);
      t++;
    end
    chk("to_start", 32'(ps2d), 0);
    wait_done(d0, TO_CYC + 500, t);
    chk("to_window", 32'(t >= TO_CYC - 10 && t <= TO_CYC + 10), 1);
    repeat (2) @(negedge mclk);
    chk("to_done", 32'(done_cnt), 32'(d0 + 1));
    chk("to_err", 32'(err_at_done), 1);
    chk("to_idle", 32'(idle_at_done), 1);
    chk("to_ps2c", 32'(ps2c), 1);
    chk("to_ps2d", 32'(ps2d), 1);
    d0 = done_cnt;
    request(PS2_CMD_SET_LED);
    kbd(1'b1, 1'b1, 1'b0, got, low_cyc, sb);
    chk("busy_bits", 32'(got), 32'h3ED);
    wait_done(d0, 200, t);
    repeat (50) @(negedge mclk);
    chk("busy_done", 32'(done_cnt), 32'(d0 + 1));
    chk("busy_err", 32'(err_at_done), 0);
    chk("busy_noqueue", 32'(bus.tx_idle), 1);
    chk("busy_line", 32'(ps2c), 1);
    d0 = done_cnt;
    request(PS2_CMD_SET_LED);
    kbd(1'b1, 1'b0, 1'b1, got, low_cyc, sb);
    chk("glitch_bits", 32'(got), 32'h3ED);
    wait_done(d0, 200, t);
    repeat (5) @(negedge mclk);
    chk("glitch_done", 32'(done_cnt), 32'(d0 + 1));
    chk("glitch_err", 32'(err_at_done), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
